mem_port_arbiter: RTL and testbench

- Owns the single-port memory controller.
- Arbitrates it between instruction fetch (IF) and load/store (MEM).
- Merges the resulting wait conditions, plus the ID load-use request, into the pipeline stall vector consumed by PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- On a jump it drops an in-flight fetch so no stale instruction reaches ID.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_stall_merge.sv | 33 +++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, stall
// vector bit positions, access length codes and pipeline control levels.
package mem_port_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        IF_DROP  = 2'd3
    } arb_state_t;

    // Stall vector bit positions, one per pipeline register
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // Access length codes (bytes)
    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // Active levels of the shared pipeline control signals
    localparam logic STALL  = 1'b1;
    localparam logic JUMP   = 1'b1;
    localparam logic ENABLE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_stall_merge.sv
// Priority merge of the pending-request conditions into the pipeline stall
// vector. A pending load/store freezes everything up to MEM, a load-use
// hazard freezes up to ID (inserting a bubble into EX), and a pending fetch
// freezes PC and IF only. WB is never stalled.
module mem_port_arbiter_stall_merge
    import mem_port_arbiter_pkg::*;
#(
    parameter int STALL_W = 6
) (
    input  logic               mem_req,
    input  logic               mem_done,
    input  logic               id_stall_req,
    input  logic               if_req,
    input  logic               if_done,
    output logic [STALL_W-1:0] stall
);

    // Highest-priority waiting condition selects how deep the stall reaches
    always_comb begin
        stall = '0;
        if (mem_req && !mem_done) begin
            stall[STALL_MEM:STALL_PC] = {5{STALL}};
        end else if (id_stall_req) begin
            stall[STALL_ID:STALL_PC] = {3{STALL}};
        end else if (if_req && !if_done) begin
            stall[STALL_IF:STALL_PC] = {2{STALL}};
        end else begin
            stall = '0;
        end
        stall[STALL_WB] = 1'b0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory controller between instruction fetch and
// load/store. Load/store wins ties unless fetch has been passed over
// STARVE_MAX times in a row. A jump while a fetch is outstanding turns that
// fetch into a drop so its stale data never reaches ID.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STALL_W    = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               pcJump_in,
    input  logic               id_stallReq_in,
    input  logic               if_req_in,
    input  logic [ADDR_W-1:0]  if_addr_in,
    output logic               if_done_out,
    output logic [DATA_W-1:0]  if_inst_out,
    input  logic               mem_req_in,
    input  logic               mem_we_in,
    input  logic [2:0]         mem_len_in,
    input  logic [ADDR_W-1:0]  mem_addr_in,
    input  logic [DATA_W-1:0]  mem_wdata_in,
    output logic               mem_done_out,
    output logic [DATA_W-1:0]  mem_rdata_out,
    output logic               mc_valid_out,
    output logic               mc_we_out,
    output logic [2:0]         mc_len_out,
    output logic [ADDR_W-1:0]  mc_addr_out,
    output logic [DATA_W-1:0]  mc_wdata_out,
    input  logic               mc_done_in,
    input  logic [DATA_W-1:0]  mc_rdata_in,
    output logic [STALL_W-1:0] stall_out
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t        state_r, state_s;
    logic [3:0]        starve_r, starve_s;
    logic              mc_valid_r, mc_valid_s;
    logic              mc_we_r, mc_we_s;
    logic [2:0]        mc_len_r, mc_len_s;
    logic [ADDR_W-1:0] mc_addr_r, mc_addr_s;
    logic [DATA_W-1:0] mc_wdata_r, mc_wdata_s;
    logic              if_done_r, if_done_s;
    logic [DATA_W-1:0] if_inst_r, if_inst_s;
    logic              mem_done_r, mem_done_s;
    logic [DATA_W-1:0] mem_rdata_r, mem_rdata_s;

    // State, starve counter and all outputs are registered together
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r     <= IDLE;
            starve_r    <= 4'd0;
            mc_valid_r  <= 1'b0;
            mc_we_r     <= 1'b0;
            mc_len_r    <= 3'd0;
            mc_addr_r   <= '0;
            mc_wdata_r  <= '0;
            if_done_r   <= 1'b0;
            if_inst_r   <= '0;
            mem_done_r  <= 1'b0;
            mem_rdata_r <= '0;
        end else begin
            state_r     <= state_s;
            starve_r    <= starve_s;
            mc_valid_r  <= mc_valid_s;
            mc_we_r     <= mc_we_s;
            mc_len_r    <= mc_len_s;
            mc_addr_r   <= mc_addr_s;
            mc_wdata_r  <= mc_wdata_s;
            if_done_r   <= if_done_s;
            if_inst_r   <= if_inst_s;
            mem_done_r  <= mem_done_s;
            mem_rdata_r <= mem_rdata_s;
        end
    end

    // Next-state and next-output decode; pulses default low, data holds
    always_comb begin
        state_s     = state_r;
        starve_s    = starve_r;
        mc_valid_s  = 1'b0;
        mc_we_s     = mc_we_r;
        mc_len_s    = mc_len_r;
        mc_addr_s   = mc_addr_r;
        mc_wdata_s  = mc_wdata_r;
        if_done_s   = 1'b0;
        if_inst_s   = if_inst_r;
        mem_done_s  = 1'b0;
        mem_rdata_s = mem_rdata_r;
        if (rdy_in != ENABLE) begin
            // frozen: everything, pulses included, keeps its value
            mc_valid_s = mc_valid_r;
            if_done_s  = if_done_r;
            mem_done_s = mem_done_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_req_in && !(if_req_in && (starve_r == STARVE_LIM))) begin
                        state_s    = MEM_BUSY;
                        mc_valid_s = 1'b1;
                        mc_we_s    = mem_we_in;
                        mc_len_s   = mem_len_in;
                        mc_addr_s  = mem_addr_in;
                        mc_wdata_s = mem_wdata_in;
                        if (if_req_in) begin
                            starve_s = (starve_r == STARVE_LIM) ? starve_r : starve_r + 4'd1;
                        end else begin
                            starve_s = 4'd0;
                        end
                    end else if (if_req_in && (pcJump_in != JUMP)) begin
                        state_s    = IF_BUSY;
                        mc_valid_s = 1'b1;
                        mc_we_s    = 1'b0;
                        mc_len_s   = LEN_W;
                        mc_addr_s  = if_addr_in;
                        starve_s   = 4'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                MEM_BUSY: begin
                    if (mc_done_in) begin
                        mem_done_s = 1'b1;
                        state_s    = IDLE;
                        if (!mc_we_r) begin
                            mem_rdata_s = mc_rdata_in;
                        end else begin
                            mem_rdata_s = mem_rdata_r;
                        end
                    end else begin
                        state_s = MEM_BUSY;
                    end
                end
                IF_BUSY: begin
                    case ({pcJump_in, mc_done_in})
                        2'b10: state_s = IF_DROP;
                        2'b01: begin
                            if_done_s = 1'b1;
                            if_inst_s = mc_rdata_in;
                            state_s   = IDLE;
                        end
                        2'b11: state_s = IDLE;
                        default: state_s = IF_BUSY;
                    endcase
                end
                IF_DROP: begin
                    if (mc_done_in) begin
                        state_s = IDLE;
                    end else begin
                        state_s = IF_DROP;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    mem_port_arbiter_stall_merge #(
        .STALL_W (STALL_W)
    ) u_stall_merge (
        .mem_req      (mem_req_in),
        .mem_done     (mem_done_r),
        .id_stall_req (id_stallReq_in),
        .if_req       (if_req_in),
        .if_done      (if_done_r),
        .stall        (stall_out)
    );

    assign mc_valid_out  = mc_valid_r;
    assign mc_we_out     = mc_we_r;
    assign mc_len_out    = mc_len_r;
    assign mc_addr_out   = mc_addr_r;
    assign mc_wdata_out  = mc_wdata_r;
    assign if_done_out   = if_done_r;
    assign if_inst_out   = if_inst_r;
    assign mem_done_out  = mem_done_r;
    assign mem_rdata_out = mem_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The memory controller is played by
// the bench itself, driving mc_done_in/mc_rdata_in on hand-picked cycles.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STALL_W = 6;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               rdy_in;
    logic               pcJump_in;
    logic               id_stallReq_in;
    logic               if_req_in;
    logic [ADDR_W-1:0]  if_addr_in;
    logic               if_done_out;
    logic [DATA_W-1:0]  if_inst_out;
    logic               mem_req_in;
    logic               mem_we_in;
    logic [2:0]         mem_len_in;
    logic [ADDR_W-1:0]  mem_addr_in;
    logic [DATA_W-1:0]  mem_wdata_in;
    logic               mem_done_out;
    logic [DATA_W-1:0]  mem_rdata_out;
    logic               mc_valid_out;
    logic               mc_we_out;
    logic [2:0]         mc_len_out;
    logic [ADDR_W-1:0]  mc_addr_out;
    logic [DATA_W-1:0]  mc_wdata_out;
    logic               mc_done_in;
    logic [DATA_W-1:0]  mc_rdata_in;
    logic [STALL_W-1:0] stall_out;

    int err_cnt = 0;
    int chk_cnt = 0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STALL_W    (STALL_W),
        .STARVE_MAX (2)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .pcJump_in      (pcJump_in),
        .id_stallReq_in (id_stallReq_in),
        .if_req_in      (if_req_in),
        .if_addr_in     (if_addr_in),
        .if_done_out    (if_done_out),
        .if_inst_out    (if_inst_out),
        .mem_req_in     (mem_req_in),
        .mem_we_in      (mem_we_in),
        .mem_len_in     (mem_len_in),
        .mem_addr_in    (mem_addr_in),
        .mem_wdata_in   (mem_wdata_in),
        .mem_done_out   (mem_done_out),
        .mem_rdata_out  (mem_rdata_out),
        .mc_valid_out   (mc_valid_out),
        .mc_we_out      (mc_we_out),
        .mc_len_out     (mc_len_out),
        .mc_addr_out    (mc_addr_out),
        .mc_wdata_out   (mc_wdata_out),
        .mc_done_in     (mc_done_in),
        .mc_rdata_in    (mc_rdata_in),
        .stall_out      (stall_out)
    );

    // 10 ns clock
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    logic [31:0] exp_addr [4];
    int          mem_left;

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; pcJump_in = 1'b0; id_stallReq_in = 1'b0;
        if_req_in = 1'b0; if_addr_in = 32'h0;
        mem_req_in = 1'b0; mem_we_in = 1'b0; mem_len_in = 3'd0;
        mem_addr_in = 32'h0; mem_wdata_in = 32'h0;
        mc_done_in = 1'b0; mc_rdata_in = 32'h0;

        // reset state
        #12;
        check_eq("rst_stall", 32'(stall_out), 32'h0);
        check_eq("rst_mc_valid", 32'(mc_valid_out), 32'h0);
        check_eq("rst_mc_addr", mc_addr_out, 32'h0);
        check_eq("rst_mc_len", 32'(mc_len_out), 32'h0);
        check_eq("rst_if_done", 32'(if_done_out), 32'h0);
        check_eq("rst_mem_done", 32'(mem_done_out), 32'h0);
        check_eq("rst_if_inst", if_inst_out, 32'h0);
        check_eq("rst_mem_rdata", mem_rdata_out, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // fetch only
        if_req_in = 1'b1; if_addr_in = 32'h0000_1000;
        #1 check_eq("fetch_stall_pre", 32'(stall_out), 32'h03);
        tick;
        check_eq("fetch_valid", 32'(mc_valid_out), 32'h1);
        check_eq("fetch_addr", mc_addr_out, 32'h0000_1000);
        check_eq("fetch_len", 32'(mc_len_out), 32'h4);
        check_eq("fetch_we", 32'(mc_we_out), 32'h0);
        check_eq("fetch_stall_busy", 32'(stall_out), 32'h03);
        tick;
        check_eq("fetch_valid_pulse", 32'(mc_valid_out), 32'h0);
        mc_done_in = 1'b1; mc_rdata_in = 32'h0000_0013;
        tick;
        mc_done_in = 1'b0;
        check_eq("fetch_done", 32'(if_done_out), 32'h1);
        check_eq("fetch_inst", if_inst_out, 32'h0000_0013);
        check_eq("fetch_stall_done", 32'(stall_out), 32'h00);
        if_req_in = 1'b0;
        tick;
        check_eq("fetch_done_pulse", 32'(if_done_out), 32'h0);
        check_eq("fetch_no_regrant", 32'(mc_valid_out), 32'h0);

        // simultaneous requests: MEM first, IF after one idle cycle
        mem_req_in = 1'b1; mem_we_in = 1'b0; mem_len_in = 3'd4; mem_addr_in = 32'h0000_2000;
        if_req_in = 1'b1; if_addr_in = 32'h0000_1004;
        #1 check_eq("simul_stall", 32'(stall_out), 32'h1F);
        tick;
        check_eq("simul_mem_valid", 32'(mc_valid_out), 32'h1);
        check_eq("simul_mem_addr", mc_addr_out, 32'h0000_2000);
        check_eq("simul_mem_stall", 32'(stall_out), 32'h1F);
        tick;
        mc_done_in = 1'b1; mc_rdata_in = 32'hCAFE_F00D;
        tick;
        mc_done_in = 1'b0;
        check_eq("simul_mem_done", 32'(mem_done_out), 32'h1);
        check_eq("simul_mem_rdata", mem_rdata_out, 32'hCAFE_F00D);
        check_eq("simul_turnaround", 32'(mc_valid_out), 32'h0);
        check_eq("simul_stall_if", 32'(stall_out), 32'h03);
        mem_req_in = 1'b0;
        tick;
        check_eq("simul_if_valid", 32'(mc_valid_out), 32'h1);
        check_eq("simul_if_addr", mc_addr_out, 32'h0000_1004);
        tick;
        mc_done_in = 1'b1; mc_rdata_in = 32'h0010_0093;
        tick;
        mc_done_in = 1'b0;
        check_eq("simul_if_done", 32'(if_done_out), 32'h1);
        check_eq("simul_if_inst", if_inst_out, 32'h0010_0093);
        if_req_in = 1'b0;
        tick;

        // jump in IDLE blocks the fetch for that cycle
        if_req_in = 1'b1; if_addr_in = 32'h0000_1008; pcJump_in = 1'b1;
        tick;
        check_eq("jidle_no_grant", 32'(mc_valid_out), 32'h0);
        pcJump_in = 1'b0;
        tick;
        check_eq("jidle_grant", 32'(mc_valid_out), 32'h1);
        check_eq("jidle_addr", mc_addr_out, 32'h0000_1008);

        // jump during fetch: data dropped
        pcJump_in = 1'b1;
        tick;
        pcJump_in = 1'b0; mc_done_in = 1'b1; mc_rdata_in = 32'hDEAD_BEEF;
        if_addr_in = 32'h0000_2000;
        tick;
        mc_done_in = 1'b0;
        check_eq("jdrop_no_done", 32'(if_done_out), 32'h0);
        check_eq("jdrop_inst_kept", if_inst_out, 32'h0010_0093);
        tick;
        check_eq("jdrop_idle_grant", 32'(mc_valid_out), 32'h1);
        check_eq("jdrop_new_addr", mc_addr_out, 32'h0000_2000);

        // completion and jump in the same cycle
        tick;
        mc_done_in = 1'b1; pcJump_in = 1'b1; mc_rdata_in = 32'h1111_1111;
        if_addr_in = 32'h0000_3000;
        tick;
        mc_done_in = 1'b0; pcJump_in = 1'b0;
        check_eq("jdone_no_done", 32'(if_done_out), 32'h0);
        check_eq("jdone_inst_kept", if_inst_out, 32'h0010_0093);
        tick;
        check_eq("jdone_grant", 32'(mc_valid_out), 32'h1);
        check_eq("jdone_addr", mc_addr_out, 32'h0000_3000);
        tick;
        mc_done_in = 1'b1; mc_rdata_in = 32'h2222_2222;
        tick;
        mc_done_in = 1'b0;
        check_eq("jdone_refetch", 32'(if_done_out), 32'h1);
        check_eq("jdone_inst", if_inst_out, 32'h2222_2222);
        if_req_in = 1'b0;
        tick;

        // byte store: fields forwarded, load data untouched
        mem_req_in = 1'b1; mem_we_in = 1'b1; mem_len_in = 3'd1;
        mem_addr_in = 32'h0000_5001; mem_wdata_in = 32'h0000_00AB;
        tick;
        check_eq("st_valid", 32'(mc_valid_out), 32'h1);
        check_eq("st_we", 32'(mc_we_out), 32'h1);
        check_eq("st_len", 32'(mc_len_out), 32'h1);
        check_eq("st_addr", mc_addr_out, 32'h0000_5001);
        check_eq("st_wdata", mc_wdata_out, 32'h0000_00AB);
        tick;
        mc_done_in = 1'b1; mc_rdata_in = 32'h9999_9999;
        tick;
        mc_done_in = 1'b0;
        check_eq("st_done", 32'(mem_done_out), 32'h1);
        check_eq("st_rdata_kept", mem_rdata_out, 32'hCAFE_F00D);
        mem_req_in = 1'b0; mem_we_in = 1'b0;
        tick;

        // load-use only
        id_stallReq_in = 1'b1;
        #1 check_eq("loaduse_stall", 32'(stall_out), 32'h07);
        id_stallReq_in = 1'b0;
        #1 check_eq("quiet_stall", 32'(stall_out), 32'h00);

        // starvation with STARVE_MAX = 2: MEM, MEM, IF, MEM
        exp_addr[0] = 32'h0000_3000; exp_addr[1] = 32'h0000_3000;
        exp_addr[2] = 32'h0000_4000; exp_addr[3] = 32'h0000_3000;
        mem_left = 3;
        mem_req_in = 1'b1; mem_we_in = 1'b0; mem_len_in = 3'd4; mem_addr_in = 32'h0000_3000;
        if_req_in = 1'b1; if_addr_in = 32'h0000_4000;
        tick;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("starve_valid%0d", i), 32'(mc_valid_out), 32'h1);
            check_eq($sformatf("starve_addr%0d", i), mc_addr_out, exp_addr[i]);
            tick;
            mc_done_in = 1'b1; mc_rdata_in = 32'h100 + 32'(i);
            tick;
            mc_done_in = 1'b0;
            if (exp_addr[i] == 32'h0000_4000) begin
                check_eq("starve_if_done", 32'(if_done_out), 32'h1);
                check_eq("starve_if_inst", if_inst_out, 32'h0000_0102);
                if_req_in = 1'b0;
            end else begin
                check_eq($sformatf("starve_mem_done%0d", i), 32'(mem_done_out), 32'h1);
                mem_left--;
                if (mem_left == 0) mem_req_in = 1'b0;
            end
            tick;
        end
        check_eq("starve_last_rdata", mem_rdata_out, 32'h0000_0103);

        // async reset while MEM_BUSY
        mem_req_in = 1'b1; mem_we_in = 1'b0; mem_len_in = 3'd4; mem_addr_in = 32'h0000_6000;
        tick;
        check_eq("rmid_valid", 32'(mc_valid_out), 32'h1);
        #2;
        rst_in = 1'b1; mem_req_in = 1'b0;
        #1;
        check_eq("rmid_valid0", 32'(mc_valid_out), 32'h0);
        check_eq("rmid_addr0", mc_addr_out, 32'h0);
        check_eq("rmid_len0", 32'(mc_len_out), 32'h0);
        check_eq("rmid_rdata0", mem_rdata_out, 32'h0);
        check_eq("rmid_inst0", if_inst_out, 32'h0);
        check_eq("rmid_stall0", 32'(stall_out), 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        if_req_in = 1'b1; if_addr_in = 32'h0000_7000;
        tick;
        check_eq("rpost_valid", 32'(mc_valid_out), 32'h1);
        check_eq("rpost_addr", mc_addr_out, 32'h0000_7000);
        tick;
        mc_done_in = 1'b1; mc_rdata_in = 32'h0000_0033;
        tick;
        mc_done_in = 1'b0;
        check_eq("rpost_done", 32'(if_done_out), 32'h1);
        check_eq("rpost_inst", if_inst_out, 32'h0000_0033);
        if_req_in = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
